// File: rtl/controle_writeback.sv
// Write-back scheduler for the register-file write port: arbitrates control
// unit, load path and shift unit writes, with one-entry load/shift slots.
// Ports: clk, reset (sync, active-high); ctrl_req/ctrl_sel/ctrl_rd/ctrl_ready;
//   load_valid/load_rd/load_ready; shift_valid/shift_rd/shift_ready;
//   registered seletor[3:0], reg_write, write_reg[4:0].
// Optional build macro WB_STALL_COUNT_EN adds output stall_count[15:0].
module controle_writeback #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ctrl_req,
   input  logic [3:0] ctrl_sel,
   input  logic [4:0] ctrl_rd,
   output logic       ctrl_ready,
   input  logic       load_valid,
   input  logic [4:0] load_rd,
   output logic       load_ready,
   input  logic       shift_valid,
   input  logic [4:0] shift_rd,
   output logic       shift_ready,
   output logic [3:0] seletor,
   output logic       reg_write,
   output logic [4:0] write_reg
`ifdef WB_STALL_COUNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic       load_pend_q, load_pend_d;
   logic [4:0] load_rd_q, load_rd_d;
   logic       shift_pend_q, shift_pend_d;
   logic [4:0] shift_rd_q, shift_rd_d;
   logic [7:0] age_load_q, age_load_d;
   logic [7:0] age_shift_q, age_shift_d;
   // 0: load is preferred next, 1: shift is preferred next
   logic       rr_q, rr_d;
   logic [3:0] seletor_q, seletor_d;
   logic       reg_write_q, reg_write_d;
   logic [4:0] write_reg_q, write_reg_d;

   logic starve_load, starve_shift;
   logic gnt_ctrl, gnt_load, gnt_shift;
   logic sel_ok;

   assign load_ready  = !load_pend_q;
   assign shift_ready = !shift_pend_q;
   assign seletor     = seletor_q;
   assign reg_write   = reg_write_q;
   assign write_reg   = write_reg_q;

   always_comb begin
      starve_load  = load_pend_q && (age_load_q >= STARVE_LIM);
      starve_shift = shift_pend_q && (age_shift_q >= STARVE_LIM);
      ctrl_ready   = !(starve_load || starve_shift);
      sel_ok       = (ctrl_sel != 4'b0000) && (ctrl_sel <= 4'b1000);

      gnt_ctrl  = 1'b0;
      gnt_load  = 1'b0;
      gnt_shift = 1'b0;
      if (starve_load) begin
         gnt_load = 1'b1;
      end else if (starve_shift) begin
         gnt_shift = 1'b1;
      end else if (ctrl_req) begin
         gnt_ctrl = 1'b1;
      end else if (load_pend_q && shift_pend_q) begin
         if (rr_q) gnt_shift = 1'b1;
         else      gnt_load  = 1'b1;
      end else if (load_pend_q) begin
         gnt_load = 1'b1;
      end else if (shift_pend_q) begin
         gnt_shift = 1'b1;
      end

      // Grant and capture never coincide: capture needs an empty slot,
      // grant needs a pending one, so a freed slot refills a cycle later.
      load_pend_d = load_pend_q;
      load_rd_d   = load_rd_q;
      if (gnt_load) begin
         load_pend_d = 1'b0;
      end else if (load_valid && load_ready) begin
         load_pend_d = 1'b1;
         load_rd_d   = load_rd;
      end

      shift_pend_d = shift_pend_q;
      shift_rd_d   = shift_rd_q;
      if (gnt_shift) begin
         shift_pend_d = 1'b0;
      end else if (shift_valid && shift_ready) begin
         shift_pend_d = 1'b1;
         shift_rd_d   = shift_rd;
      end

      age_load_d = age_load_q;
      if (!load_pend_q || gnt_load)    age_load_d = 8'd0;
      else if (age_load_q < STARVE_LIM) age_load_d = age_load_q + 8'd1;

      age_shift_d = age_shift_q;
      if (!shift_pend_q || gnt_shift)    age_shift_d = 8'd0;
      else if (age_shift_q < STARVE_LIM) age_shift_d = age_shift_q + 8'd1;

      rr_d = rr_q;
      if (gnt_load)  rr_d = 1'b1;
      if (gnt_shift) rr_d = 1'b0;

      seletor_d   = 4'b0000;
      write_reg_d = 5'd0;
      reg_write_d = 1'b0;
      if (gnt_ctrl) begin
         seletor_d   = ctrl_sel;
         write_reg_d = ctrl_rd;
         reg_write_d = sel_ok && (ctrl_rd != 5'd0);
      end else if (gnt_load) begin
         seletor_d   = 4'b0010;
         write_reg_d = load_rd_q;
         reg_write_d = (load_rd_q != 5'd0);
      end else if (gnt_shift) begin
         seletor_d   = 4'b0011;
         write_reg_d = shift_rd_q;
         reg_write_d = (shift_rd_q != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_pend_q  <= 1'b0;
         load_rd_q    <= 5'd0;
         shift_pend_q <= 1'b0;
         shift_rd_q   <= 5'd0;
         age_load_q   <= 8'd0;
         age_shift_q  <= 8'd0;
         rr_q         <= 1'b0;
         seletor_q    <= 4'b0000;
         reg_write_q  <= 1'b0;
         write_reg_q  <= 5'd0;
      end else begin
         load_pend_q  <= load_pend_d;
         load_rd_q    <= load_rd_d;
         shift_pend_q <= shift_pend_d;
         shift_rd_q   <= shift_rd_d;
         age_load_q   <= age_load_d;
         age_shift_q  <= age_shift_d;
         rr_q         <= rr_d;
         seletor_q    <= seletor_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
      end
   end

`ifdef WB_STALL_COUNT_EN
   logic [15:0] stall_count_q, stall_count_d;

   assign stall_count = stall_count_q;

   always_comb begin
      stall_count_d = stall_count_q;
      if (ctrl_req && !ctrl_ready && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_count_q <= 16'd0;
      else       stall_count_q <= stall_count_d;
   end
`endif

endmodule

// File: tb/tb_controle_writeback.sv
// Scoreboard bench for controle_writeback: directed stimulus pushes the
// expected write-port output (with its cycle) and a negedge monitor checks it.
module tb_controle_writeback;

   logic       clk;
   logic       reset;
   logic       ctrl_req;
   logic [3:0] ctrl_sel;
   logic [4:0] ctrl_rd;
   logic       ctrl_ready;
   logic       load_valid;
   logic [4:0] load_rd;
   logic       load_ready;
   logic       shift_valid;
   logic [4:0] shift_rd;
   logic       shift_ready;
   logic [3:0] seletor;
   logic       reg_write;
   logic [4:0] write_reg;
`ifdef WB_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   controle_writeback #(.STARVE_MAX(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl_req    (ctrl_req),
      .ctrl_sel    (ctrl_sel),
      .ctrl_rd     (ctrl_rd),
      .ctrl_ready  (ctrl_ready),
      .load_valid  (load_valid),
      .load_rd     (load_rd),
      .load_ready  (load_ready),
      .shift_valid (shift_valid),
      .shift_rd    (shift_rd),
      .shift_ready (shift_ready),
      .seletor     (seletor),
      .reg_write   (reg_write),
      .write_reg   (write_reg)
`ifdef WB_STALL_COUNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   typedef struct {
      int         cyc;
      logic [3:0] sel;
      logic [4:0] rd;
      logic       we;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input logic [3:0] s,
                       input logic [4:0] r, input logic w);
      exp_t e;
      e.cyc = c;
      e.sel = s;
      e.rd  = r;
      e.we  = w;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one write-port sample per cycle, at the falling edge
   always @(negedge clk) begin
      if (cyc >= 1 && !done) begin
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            chk("sb_missed_slot", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("seletor", int'(seletor), int'(e.sel));
            chk("write_reg", int'(write_reg), int'(e.rd));
            chk("reg_write", int'(reg_write), int'(e.we));
         end else begin
            chk("idle_seletor", int'(seletor), 0);
            chk("idle_write_reg", int'(write_reg), 0);
            chk("idle_reg_write", int'(reg_write), 0);
         end
      end
   end

   initial begin
      int rd;
      reset       = 1'b1;
      ctrl_req    = 1'b1;
      ctrl_sel    = 4'b0100;
      ctrl_rd     = 5'd1;
      load_valid  = 1'b1;
      load_rd     = 5'd2;
      shift_valid = 1'b1;
      shift_rd    = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b0;
      ctrl_req    = 1'b0;
      load_valid  = 1'b0;
      shift_valid = 1'b0;
      chk("rst_load_ready", int'(load_ready), 1);
      chk("rst_shift_ready", int'(shift_ready), 1);
      chk("rst_ctrl_ready", int'(ctrl_ready), 1);
      step();

      // Plain control write, then an idle cycle
      ctrl_req = 1'b1; ctrl_sel = 4'b0100; ctrl_rd = 5'd9;
      push(cyc + 1, 4'b0100, 5'd9, 1'b1);
      step();
      ctrl_req = 1'b0;
      step();

      // Wasted control grants: bad selectors and rd 0
      ctrl_req = 1'b1; ctrl_sel = 4'b0000; ctrl_rd = 5'd4;
      push(cyc + 1, 4'b0000, 5'd4, 1'b0);
      step();
      ctrl_sel = 4'b1001; ctrl_rd = 5'd6;
      push(cyc + 1, 4'b1001, 5'd6, 1'b0);
      step();
      ctrl_sel = 4'b1000; ctrl_rd = 5'd0;
      push(cyc + 1, 4'b1000, 5'd0, 1'b0);
      step();
      ctrl_sel = 4'b1000; ctrl_rd = 5'd31;
      push(cyc + 1, 4'b1000, 5'd31, 1'b1);
      step();
      ctrl_req = 1'b0;
      step();

      // Single load, rd 5
      load_valid = 1'b1; load_rd = 5'd5;
      push(cyc + 2, 4'b0010, 5'd5, 1'b1);
      step();
      load_valid = 1'b0;
      chk("load_ready_busy", int'(load_ready), 0);
      step();
      chk("load_ready_freed", int'(load_ready), 1);
      step();

      // Single shift, rd 15
      shift_valid = 1'b1; shift_rd = 5'd15;
      push(cyc + 2, 4'b0011, 5'd15, 1'b1);
      step();
      shift_valid = 1'b0;
      chk("shift_ready_busy", int'(shift_ready), 0);
      step();
      chk("shift_ready_freed", int'(shift_ready), 1);
      step();

      // Two simultaneous pairs: load first both times
      load_valid = 1'b1; load_rd = 5'd3;
      shift_valid = 1'b1; shift_rd = 5'd7;
      push(cyc + 2, 4'b0010, 5'd3, 1'b1);
      push(cyc + 3, 4'b0011, 5'd7, 1'b1);
      step();
      load_valid = 1'b0; shift_valid = 1'b0;
      repeat (3) step();
      load_valid = 1'b1; load_rd = 5'd10;
      shift_valid = 1'b1; shift_rd = 5'd11;
      push(cyc + 2, 4'b0010, 5'd10, 1'b1);
      push(cyc + 3, 4'b0011, 5'd11, 1'b1);
      step();
      load_valid = 1'b0; shift_valid = 1'b0;
      repeat (3) step();

      // Starvation: load pending while control requests every cycle
      load_valid = 1'b1; load_rd = 5'd12;
      step();
      load_valid = 1'b0;
      rd = 20;
      for (int i = 0; i < 6; i++) begin
         ctrl_req = 1'b1; ctrl_sel = 4'b0100; ctrl_rd = 5'(rd);
         chk("starve_ctrl_ready", int'(ctrl_ready), (i == 4) ? 0 : 1);
         if (i == 4) begin
            push(cyc + 1, 4'b0010, 5'd12, 1'b1);
         end else begin
            push(cyc + 1, 4'b0100, 5'(rd), 1'b1);
            rd++;
         end
         step();
      end
      ctrl_req = 1'b0;
      chk("starve_load_ready", int'(load_ready), 1);
`ifdef WB_STALL_COUNT_EN
      chk("stall_count", int'(stall_count), 1);
`endif
      step();

      // Load to register 0: granted, no write
      load_valid = 1'b1; load_rd = 5'd0;
      push(cyc + 2, 4'b0010, 5'd0, 1'b0);
      step();
      load_valid = 1'b0;
      step();
      chk("load0_ready_freed", int'(load_ready), 1);
      step();

      // Reset with both slots pending: nothing is ever written
      load_valid = 1'b1; load_rd = 5'd8;
      shift_valid = 1'b1; shift_rd = 5'd9;
      step();
      load_valid = 1'b0; shift_valid = 1'b0;
      chk("pre_rst_load_ready", int'(load_ready), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("post_rst_load_ready", int'(load_ready), 1);
      chk("post_rst_shift_ready", int'(shift_ready), 1);
`ifdef WB_STALL_COUNT_EN
      chk("post_rst_stall_count", int'(stall_count), 0);
`endif
      repeat (4) step();

      for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
      chk("sb_drained", sbq.size(), 0);
      @(posedge clk);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
